// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL dynamic phase-adjust initiator.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_GAP,
    ST_LOCKWAIT
  } state_t;

  localparam logic [1:0] SEL_CLKOS  = 2'd0;
  localparam logic [1:0] SEL_CLKOS2 = 2'd1;
  localparam logic [1:0] SEL_CLKOS3 = 2'd2;
  localparam logic [1:0] SEL_CLKOP  = 2'd3;

  localparam logic DIR_ADV = 1'b0;
  localparam logic DIR_RET = 1'b1;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow level signals such as PLL lock.
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_phase_stepper.sv
// Drives PHASESEL/PHASEDIR/PHASESTEP of an EHXPLLL, waits for relock and tracks
// the accumulated step position of each PLL output.
module pll_phase_stepper
  import pll_phase_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 4,
  parameter int unsigned STEP_W       = 8,
  parameter int unsigned POS_W        = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_sel,
  input  logic                 req_dir,
  input  logic [STEP_W-1:0]    req_steps,
  input  logic                 pll_locked,
  output logic [1:0]           phasesel,
  output logic                 phasedir,
  output logic                 phasestep,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [4*POS_W-1:0]   pos
);

  localparam int unsigned CNT_MAX =
    max_of(max_of(SETUP_CYCLES, PULSE_CYCLES), max_of(GAP_CYCLES, LOCK_TIMEOUT));
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD  = CNT_W'(LOCK_TIMEOUT - 1);

  state_t                     state;
  logic [CNT_W-1:0]           cnt;
  logic [STEP_W-1:0]          steps_left;
  logic [3:0][POS_W-1:0]      pos_q;
  logic                       lock_s;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  assign pos = pos_q;

  // Every state holds for a counted number of cycles; cnt==0 marks the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      steps_left <= '0;
      pos_q      <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      phasestep  <= 1'b0;
      phasesel   <= SEL_CLKOS;
      phasedir   <= DIR_ADV;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            phasesel   <= req_sel;
            phasedir   <= req_dir;
            steps_left <= req_steps;
            err        <= 1'b0;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            cnt        <= SETUP_LOAD;
            state      <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          if (cnt == '0) begin
            if (steps_left == '0) begin
              cnt   <= LOCK_LOAD;
              state <= ST_LOCKWAIT;
            end else begin
              phasestep <= 1'b1;
              cnt       <= PULSE_LOAD;
              state     <= ST_PULSE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_PULSE: begin
          if (cnt == '0) begin
            phasestep  <= 1'b0;
            steps_left <= steps_left - STEP_W'(1);
            // Position follows the falling edge of each completed step, mod 2^POS_W.
            if (phasedir == DIR_RET) begin
              pos_q[phasesel] <= pos_q[phasesel] - POS_W'(1);
            end else begin
              pos_q[phasesel] <= pos_q[phasesel] + POS_W'(1);
            end
            cnt   <= GAP_LOAD;
            state <= ST_GAP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_GAP: begin
          if (cnt == '0) begin
            if (steps_left != '0) begin
              phasestep <= 1'b1;
              cnt       <= PULSE_LOAD;
              state     <= ST_PULSE;
            end else begin
              cnt   <= LOCK_LOAD;
              state <= ST_LOCKWAIT;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_LOCKWAIT: begin
          if (lock_s) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else if (cnt == '0) begin
            err       <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: begin
          phasestep <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_phase_stepper.md
Name: pll_phase_stepper

Overview:
Initiator side of the ECP5 EHXPLLL dynamic phase-adjust port (PHASESEL/PHASEDIR/PHASESTEP), which the board clock generators currently tie off.
- Accepts phase-shift requests over a valid/ready handshake.
- Sequences the PHASESTEP pulses with parameterised setup, pulse and gap timing.
- Waits for the PLL lock to be re-qualified after the last step.
- Tracks the accumulated step position of each of the four PLL outputs.
- Sits next to the board clock-generator instance and is clocked by a free-running fabric clock (not a PLL output).

Parameters:
- SETUP_CYCLES, 2: cycles PHASESEL/PHASEDIR are held stable before the first PHASESTEP rise.
- PULSE_CYCLES, 4: PHASESTEP high time, in clk cycles; must be >=1.
- GAP_CYCLES, 4: PHASESTEP low time after each pulse; must be >=1.
- STEP_W, 8: width of the requested step count.
- POS_W, 8: width of each per-output position counter.
- LOCK_TIMEOUT, 1024: max cycles in LOCKWAIT before err is raised.

Ports:
- clk  in  1  fabric clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept a request
- req_sel  in  2  output select (00 CLKOS, 01 CLKOS2, 10 CLKOS3, 11 CLKOP)
- req_dir  in  1  0 = advance (+1 per step), 1 = retard (-1 per step)
- req_steps  in  STEP_W  number of steps
- pll_locked  in  1  PLL LOCK, asynchronous to clk
- phasesel  out  2  to PLL PHASESEL1:0
- phasedir  out  1  to PLL PHASEDIR
- phasestep  out  1  to PLL PHASESTEP
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at successful completion
- err  out  1  sticky lock-timeout flag; cleared only by rst or by accepting the next request
- pos  out  4*POS_W  per-output position; slice k belongs to sel code k

Behaviour:
- Reset values: req_ready=1, busy=0, done=0, err=0, phasestep=0, phasesel=00, phasedir=0, all pos=0, FSM=IDLE, sync flops=0.
- Reset mid-operation: at the next edge all outputs take their reset values; a pulse in flight is truncated; pos is cleared.
- pll_locked passes through a 2-flop synchroniser to give lock_s. All decisions use lock_s only.
- Handshake: a request is accepted on the edge where req_valid & req_ready. At that edge req_sel, req_dir and req_steps are registered and err is cleared. req_ready=0 from the next cycle until the FSM returns to IDLE. Requests are ignored while busy.
- FSM states: IDLE -> SETUP -> PULSE -> GAP -> {PULSE | LOCKWAIT} -> IDLE.
- SETUP: phasesel/phasedir driven from the registered request and held constant until IDLE. Lasts SETUP_CYCLES cycles. Exits to LOCKWAIT if steps=0, else to PULSE.
- PULSE: phasestep=1 for PULSE_CYCLES cycles. On the last PULSE cycle, pos[sel] += 1 (dir=0) or -= 1 (dir=1), modulo 2^POS_W (wraps 255 -> 0 and 0 -> 255). The remaining-step count decrements at the same edge.
- GAP: phasestep=0 for GAP_CYCLES cycles. Exits to PULSE if steps remain, else to LOCKWAIT.
- LOCKWAIT: if lock_s=1, done=1 for one cycle and go to IDLE. If lock_s stays 0 for LOCK_TIMEOUT cycles, set err=1 (no done) and go to IDLE.
- Timing: with the accept edge at cycle A and lock_s already high:
  - SETUP starts at A+1.
  - First phasestep rise at A+1+S.
  - done asserted at A+2+S+N*(P+G), where S=SETUP_CYCLES, P=PULSE_CYCLES, G=GAP_CYCLES, N=req_steps.
  - For N=0: done at A+2+S with no phasestep pulse.
- lock_s dropping during PULSE/GAP does not abort stepping; only LOCKWAIT evaluates lock.
- phasestep is registered and glitch-free; phasesel/phasedir never change while phasestep=1 or within SETUP.

Decomposition:
- Shared package pll_phase_pkg:
  - FSM state enum.
  - sel code constants SEL_CLKOS=0, SEL_CLKOS2=1, SEL_CLKOS3=2, SEL_CLKOP=3.
  - DIR_ADV=0, DIR_RET=1.
- Sub-module sync_2ff for the pll_locked synchroniser, reusable by other lock consumers.
- FSM, cycle counter, step counter and position registers stay in the top module.

Test Plan:
- Reset then idle -> req_ready=1, busy=0, phasestep=0, pos all 0, err=0.
- Request sel=01, dir=0, steps=3, locked=1 held, defaults (A=0):
  - phasesel=01 from cycle 1; phasestep high at cycles 3-6, 11-14, 19-22.
  - done at cycle 28; pos[1]=3; other slices 0.
- Request sel=11, dir=1, steps=2 from pos[3]=0 -> pos[3]=254 (wrap); phasedir=1 throughout.
- Request steps=0 -> no phasestep pulse; done at A+4.
- locked=0 through LOCKWAIT -> err=1 after 1024 LOCKWAIT cycles, no done. Next accepted request clears err.
- Mid-operation and handshake checks:
  - rst asserted during the second PULSE of a 5-step request -> next cycle phasestep=0, pos=0, req_ready=1.
  - req_valid held while busy -> second request accepted only at the IDLE cycle after done.
